// File: rtl/mem_responder.sv
// mem_responder: the memory side of the cache<->memory block interface.
// Serves one block read or write per accepted request. The access stays
// in flight for LATENCY clocks, and completion is marked by a one-cycle
// memDone pulse. The block array powers up and resets to a known pattern:
// 32-bit word w holds the value w.

module mem_responder #(
   parameter int LATENCY    = 4,    // clocks from acceptance to memDone, 1..15
   parameter int NUM_BLOCKS = 64,   // blocks stored; index = memAddress[9:4]
   parameter int BLOCK_BITS = 128   // bits per block, word0 = bits[31:0]
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  memReq,
   input  logic                  isMemRead,
   input  logic [31:0]           memAddress,
   input  logic [BLOCK_BITS-1:0] memWriteData,
   output logic [BLOCK_BITS-1:0] memReadData,
   output logic                  isLock,
   output logic                  memDone
);

   localparam int IDX_W = $clog2(NUM_BLOCKS);
   localparam int WORDS = BLOCK_BITS / 32;
   localparam int IDX_LO = 4;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [3:0]              count_q;
   logic [IDX_W-1:0]        idx_q;
   logic                    rd_q;
   logic [BLOCK_BITS-1:0]   wdata_q;
   logic [BLOCK_BITS-1:0]   mem_q [NUM_BLOCKS];

   logic                    accept;
   logic                    complete;
   logic [IDX_W-1:0]        req_idx;
   logic                    unused_addr;

   // Only the block-index bits of the byte address select storage; the
   // byte offset and upper bits alias onto the same 1 KB window.
   assign req_idx     = memAddress[IDX_LO +: IDX_W];
   assign unused_addr = ^{memAddress[31:IDX_LO+IDX_W], memAddress[IDX_LO-1:0]};

   // A request is taken only when nothing is in flight; DONE counts as free
   // so back-to-back accesses need no idle cycle in between.
   assign accept   = memReq && ((state_q == IDLE) || (state_q == DONE));
   assign complete = (state_q == BUSY) && (count_q == 4'd0);

   // State register.
   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values, independent of the order of statements or blocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: BUSY runs until the latency counter reaches zero,
   // DONE lasts one cycle and can immediately accept the next request.
   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (memReq) state_d = BUSY;
         BUSY: if (count_q == 4'd0) state_d = DONE;
         DONE: state_d = memReq ? BUSY : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode: lock while in flight, pulse done for the single DONE cycle.
   always_comb begin
      isLock  = 1'b0;
      memDone = 1'b0;
      case (state_q)
         BUSY: isLock = 1'b1;
         DONE: memDone = 1'b1;
         default: begin
            isLock  = 1'b0;
            memDone = 1'b0;
         end
      endcase
   end

   // Request capture and latency countdown. The request is latched at
   // acceptance, so the requester may change its inputs right after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 4'd0;
         idx_q   <= '0;
         rd_q    <= 1'b0;
         wdata_q <= '0;
      end else if (accept) begin
         count_q <= CNT_LOAD;
         idx_q   <= req_idx;
         rd_q    <= isMemRead;
         wdata_q <= memWriteData;
      end else if ((state_q == BUSY) && (count_q != 4'd0)) begin
         count_q <= count_q - 4'd1;
      end
   end

   // Block array: a write lands on the completing edge, so a read issued
   // in the DONE cycle already sees the new data.
   // NOTE: the array is built from resettable flops rather than a RAM macro
   // because reset must restore the whole init pattern in one step,
   // including during an aborted access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BLOCKS; b++) begin
            for (int k = 0; k < WORDS; k++) begin
               mem_q[b][k*32 +: 32] <= 32'(b * WORDS + k);
            end
         end
      end else if (complete && !rd_q) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   // Read data register: only a completing read updates it, so it holds
   // across writes and across reads that are still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         memReadData <= '0;
      end else if (complete && rd_q) begin
         memReadData <= mem_q[idx_q];
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder. A directed
// vector table, hand-written corner sequences, and a random stream checked
// against a transaction-level memory model held in this bench.

module tb_mem_responder;

   localparam int LAT = 4;

   typedef struct {
      logic         rd;
      logic [31:0]  addr;
      logic [127:0] wdata;
      logic [127:0] exp_rdata;
   } vec_t;

   logic         clk;
   logic         rst_n;
   logic         memReq;
   logic         isMemRead;
   logic [31:0]  memAddress;
   logic [127:0] memWriteData;

   logic [127:0] rdata, l1_rdata, l15_rdata;
   logic         lock, l1_lock, l15_lock;
   logic         done, l1_done, l15_done;

   int errors = 0;
   int checks = 0;

   logic [127:0] model [64];
   logic [127:0] last_rd;

   mem_responder #(.LATENCY(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n), .memReq(memReq), .isMemRead(isMemRead),
      .memAddress(memAddress), .memWriteData(memWriteData),
      .memReadData(rdata), .isLock(lock), .memDone(done));

   mem_responder #(.LATENCY(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .memReq(memReq), .isMemRead(isMemRead),
      .memAddress(memAddress), .memWriteData(memWriteData),
      .memReadData(l1_rdata), .isLock(l1_lock), .memDone(l1_done));

   mem_responder #(.LATENCY(15)) u_l15 (
      .clk(clk), .rst_n(rst_n), .memReq(memReq), .isMemRead(isMemRead),
      .memAddress(memAddress), .memWriteData(memWriteData),
      .memReadData(l15_rdata), .isLock(l15_lock), .memDone(l15_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] init_block(input int b);
      return {32'(4*b+3), 32'(4*b+2), 32'(4*b+1), 32'(4*b)};
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 64; b++) model[b] = init_block(b);
      last_rd = '0;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called at a negedge with the DUT free; the request is taken at the
   // next posedge, after which the inputs are scrambled.
   task automatic start(input logic rd, input logic [31:0] addr, input logic [127:0] wd,
                        input string name);
      memReq = 1'b1; isMemRead = rd; memAddress = addr; memWriteData = wd;
      @(negedge clk);
      memReq = 1'b0; isMemRead = 1'($urandom); memAddress = $urandom; memWriteData = rand128();
      check({name, "_accept_lock"}, {127'd0, lock}, 128'd1);
   endtask

   // Counts lock cycles until memDone; optionally pokes a write request in
   // the first busy cycles, which must be ignored. Returns at the done negedge.
   task automatic wait_done(input string name, input logic rd, input logic [127:0] exp,
                            input bit noise, input logic [31:0] naddr);
      int busy = 0;
      bit seen = 0;
      for (int k = 1; k <= 40; k++) begin
         if (done) begin
            seen = 1;
            break;
         end
         if (lock) busy++;
         check({name, "_hold"}, rdata, last_rd);
         if (noise && k == 1) begin
            memReq = 1'b1; isMemRead = 1'b0; memAddress = naddr; memWriteData = rand128();
         end
         if (noise && k == 2) memReq = 1'b0;
         @(negedge clk);
      end
      check({name, "_done_seen"}, {127'd0, seen}, 128'd1);
      check({name, "_latency"}, 128'(busy), 128'(LAT));
      check({name, "_lock_at_done"}, {127'd0, lock}, 128'd0);
      check({name, "_rdata"}, rdata, exp);
      if (rd) last_rd = exp;
   endtask

   task automatic idle_check(input string name);
      @(negedge clk);
      check({name, "_idle"}, {126'd0, lock, done}, 128'd0);
   endtask

   vec_t vecs [7];

   initial begin
      logic [127:0] d_blk, e_blk, exp;
      int           at1, at4, at15;

      d_blk = 128'hDEAD0001_CAFE0002_F00D0003_0000BEEF;
      e_blk = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
      vecs[0] = '{1'b1, 32'h0000_0010, '0,    128'h00000007_00000006_00000005_00000004};
      vecs[1] = '{1'b0, 32'h0000_0020, d_blk, 128'h00000007_00000006_00000005_00000004};
      vecs[2] = '{1'b1, 32'h0000_002C, d_blk, d_blk};
      vecs[3] = '{1'b0, 32'h0000_0000, e_blk, d_blk};
      vecs[4] = '{1'b1, 32'h0000_0400, '0,    e_blk};
      vecs[5] = '{1'b1, 32'hFFFF_FFF4, '0,    128'h000000FF_000000FE_000000FD_000000FC};
      vecs[6] = '{1'b1, 32'h0000_0038, '0,    128'h0000000F_0000000E_0000000D_0000000C};

      memReq = 1'b0; isMemRead = 1'b0; memAddress = '0; memWriteData = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #2;
      check("reset_lock", {127'd0, lock}, 128'd0);
      check("reset_done", {127'd0, done}, 128'd0);
      check("reset_rdata", rdata, 128'd0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table, issued back-to-back from each DONE cycle.
      for (int i = 0; i < 7; i++) begin
         start(vecs[i].rd, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i));
         wait_done($sformatf("vec%0d", i), vecs[i].rd, vecs[i].exp_rdata, 1'b0, '0);
         if (!vecs[i].rd) model[vecs[i].addr[9:4]] = vecs[i].wdata;
      end
      idle_check("after_table");

      // Write to block 3 while busy must be dropped.
      start(1'b1, 32'h0000_00C0, '0, "busy_ign");
      wait_done("busy_ign", 1'b1, init_block(12), 1'b1, 32'h0000_0030);
      idle_check("busy_ign");
      start(1'b1, 32'h0000_0030, '0, "blk3");
      wait_done("blk3", 1'b1, 128'h0000000F_0000000E_0000000D_0000000C, 1'b0, '0);
      idle_check("blk3");

      // Reset two cycles into a write to block 0.
      start(1'b0, 32'h0000_0000, 128'h5555AAAA_5555AAAA_5555AAAA_5555AAAA, "rst_mid");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_lock", {127'd0, lock}, 128'd0);
      check("rst_mid_rdata", rdata, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      at1 = 0;
      for (int k = 0; k < 20; k++) begin
         if (done) at1++;
         @(negedge clk);
      end
      check("rst_mid_no_done", 128'(at1), 128'd0);
      start(1'b1, 32'h0000_0000, '0, "rst_blk0");
      wait_done("rst_blk0", 1'b1, 128'h00000003_00000002_00000001_00000000, 1'b0, '0);
      idle_check("rst_blk0");

      // Latency sweep: three instances see the same read from reset.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      start(1'b1, 32'h0000_0010, '0, "sweep");
      at1 = 0; at4 = 0; at15 = 0;
      for (int k = 1; k <= 30; k++) begin
         if (l1_done && at1 == 0) at1 = k;
         if (done && at4 == 0) begin
            at4 = k;
            last_rd = rdata;
         end
         if (l15_done && at15 == 0) at15 = k;
         if (k == 1) check("sweep_l15_lock", {127'd0, l15_lock}, 128'd1);
         @(negedge clk);
      end
      check("sweep_l1_at", 128'(at1), 128'd2);
      check("sweep_l4_at", 128'(at4), 128'(LAT + 1));
      check("sweep_l15_at", 128'(at15), 128'd16);
      check("sweep_l1_rdata", l1_rdata, 128'h00000007_00000006_00000005_00000004);
      check("sweep_l15_rdata", l15_rdata, 128'h00000007_00000006_00000005_00000004);
      check("sweep_l4_rdata", rdata, 128'h00000007_00000006_00000005_00000004);
      last_rd = 128'h00000007_00000006_00000005_00000004;

      // Random stream against the block model.
      for (int t = 0; t < 60; t++) begin
         logic        rd;
         logic [31:0] addr;
         logic [127:0] wd;
         int          gap;
         rd   = 1'($urandom_range(0, 1));
         addr = $urandom;
         wd   = rand128();
         exp  = rd ? model[addr[9:4]] : last_rd;
         start(rd, addr, wd, $sformatf("rnd%0d", t));
         wait_done($sformatf("rnd%0d", t), rd, exp, ($urandom_range(0, 3) == 0), $urandom);
         if (!rd) model[addr[9:4]] = wd;
         gap = $urandom_range(0, 2);
         if (gap > 0) idle_check($sformatf("rnd%0d", t));
         for (int g = 1; g < gap; g++) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
